// File: rtl/dbus_arbiter_if.sv
// Shared data-bus signal bundle between the two masters, dbus_arbiter and the DMEM/TBMAN slaves.
// The slave modport is the arbiter's view; the master modport is the masters' and slaves' view.
interface dbus_arbiter_if;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    logic        cs_dmem_n;
    logic        cs_tbman_n;
    logic [31:0] s_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be, s_rdata,
        output m_ack, m_err, m_rdata, s_addr, s_wdata, s_be, s_we, cs_dmem_n, cs_tbman_n
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be, s_rdata,
        input  m_ack, m_err, m_rdata, s_addr, s_wdata, s_be, s_we, cs_dmem_n, cs_tbman_n
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter/sequencer for DMEM and TBMAN with per-slave wait states.
// Define DBUS_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module dbus_arbiter #(
    parameter int unsigned DMEM_WAIT  = 0,
    parameter int unsigned TBMAN_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    dbus_arbiter_if.slave bus
);
    localparam logic [3:0] DmemWait  = 4'(DMEM_WAIT);
    localparam logic [3:0] TbmanWait = 4'(TBMAN_WAIT);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        unmapped_q, unmapped_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_be_q, s_be_d;
    logic        s_we_q, s_we_d;
    logic        cs_dmem_n_q, cs_dmem_n_d;
    logic        cs_tbman_n_q, cs_tbman_n_d;
    logic [1:0]  m_ack_q, m_ack_d;
    logic [1:0]  m_err_q, m_err_d;
    logic [31:0] m_rdata_q, m_rdata_d;

    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_we;
    logic        sel_dmem;
    logic        sel_tbman;

    // Winner among the current requesters; only meaningful when some m_req is high.
    always_comb begin
`ifdef DBUS_ARB_RR_EN
        if (&bus.m_req) sel = ~last_q;
        else            sel = bus.m_req[1];
`else
        sel = ~bus.m_req[0];
`endif
    end

    always_comb begin
        sel_addr  = sel ? bus.m_addr[63:32]  : bus.m_addr[31:0];
        sel_wdata = sel ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
        sel_be    = sel ? bus.m_be[7:4]      : bus.m_be[3:0];
        sel_we    = sel ? bus.m_we[1]        : bus.m_we[0];
        sel_dmem  = (sel_addr[31:28] == 4'h1);
        sel_tbman = (sel_addr[31:12] == 20'h8000F);
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        unmapped_d   = unmapped_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_be_d       = s_be_q;
        s_we_d       = s_we_q;
        cs_dmem_n_d  = cs_dmem_n_q;
        cs_tbman_n_d = cs_tbman_n_q;
        m_rdata_d    = m_rdata_q;
        m_ack_d      = 2'b00;
        m_err_d      = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (|bus.m_req) begin
                    gnt_d        = sel;
`ifdef DBUS_ARB_RR_EN
                    last_d       = sel;
`endif
                    s_addr_d     = sel_addr;
                    s_wdata_d    = sel_wdata;
                    s_be_d       = sel_be;
                    s_we_d       = sel_we;
                    cs_dmem_n_d  = ~sel_dmem;
                    cs_tbman_n_d = ~sel_tbman;
                    unmapped_d   = ~(sel_dmem | sel_tbman);
                    wcnt_d       = sel_dmem ? DmemWait : (sel_tbman ? TbmanWait : 4'd0);
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    // Slave data is taken on the edge closing the last select cycle.
                    m_rdata_d        = (s_we_q || unmapped_q) ? 32'h0 : bus.s_rdata;
                    m_ack_d[gnt_q]   = 1'b1;
                    m_err_d[gnt_q]   = unmapped_q;
                    cs_dmem_n_d      = 1'b1;
                    cs_tbman_n_d     = 1'b1;
                    s_we_d           = 1'b0;
                    s_be_d           = 4'h0;
                    state_d          = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wcnt_q       <= 4'd0;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            unmapped_q   <= 1'b0;
            s_addr_q     <= 32'h0;
            s_wdata_q    <= 32'h0;
            s_be_q       <= 4'h0;
            s_we_q       <= 1'b0;
            cs_dmem_n_q  <= 1'b1;
            cs_tbman_n_q <= 1'b1;
            m_ack_q      <= 2'b00;
            m_err_q      <= 2'b00;
            m_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            unmapped_q   <= unmapped_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_be_q       <= s_be_d;
            s_we_q       <= s_we_d;
            cs_dmem_n_q  <= cs_dmem_n_d;
            cs_tbman_n_q <= cs_tbman_n_d;
            m_ack_q      <= m_ack_d;
            m_err_q      <= m_err_d;
            m_rdata_q    <= m_rdata_d;
        end
    end

    assign bus.m_ack      = m_ack_q;
    assign bus.m_err      = m_err_q;
    assign bus.m_rdata    = m_rdata_q;
    assign bus.s_addr     = s_addr_q;
    assign bus.s_wdata    = s_wdata_q;
    assign bus.s_be       = s_be_q;
    assign bus.s_we       = s_we_q;
    assign bus.cs_dmem_n  = cs_dmem_n_q;
    assign bus.cs_tbman_n = cs_tbman_n_q;

endmodule
